// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one downstream memory port between the core's instruction-RAM
//   (iram_*) and data-RAM (dram_*) request interfaces. Requests are arbitrated
//   combinationally and forwarded unchanged. Accepted reads record their source
//   in a small ordering FIFO. In-order read responses are then steered back to
//   the requester that issued them.
//
// Parameters
//   MAX_OUTSTANDING  depth of the read-ordering FIFO (1..8)
//   DRAM_PRIORITY    1 = dram always wins, 0 = round-robin between the sides
//
// Ports
//   clk, rst_b                     clock, synchronous active-low reset
//   iram_* / dram_*                requester side: req, write, wstrb, addr,
//                                  wdata in; ready, rvalid, rdata out
//   mem_req/write/wstrb/addr/wdata downstream request (out)
//   mem_ready, mem_rvalid, mem_rdata downstream handshake and response (in)
//   resp_err                       sticky: a response arrived with no read
//                                  outstanding
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DRAM_PRIORITY   = 1
) (
  input  logic                 clk,
  input  logic                 rst_b,

  input  logic                 iram_req,
  input  logic                 iram_write,
  input  logic [`XLEN/8-1:0]   iram_wstrb,
  input  logic [`XLEN-1:0]     iram_addr,
  input  logic [`XLEN-1:0]     iram_wdata,
  output logic                 iram_ready,
  output logic                 iram_rvalid,
  output logic [`XLEN-1:0]     iram_rdata,

  input  logic                 dram_req,
  input  logic                 dram_write,
  input  logic [`XLEN/8-1:0]   dram_wstrb,
  input  logic [`XLEN-1:0]     dram_addr,
  input  logic [`XLEN-1:0]     dram_wdata,
  output logic                 dram_ready,
  output logic                 dram_rvalid,
  output logic [`XLEN-1:0]     dram_rdata,

  output logic                 mem_req,
  output logic                 mem_write,
  output logic [`XLEN/8-1:0]   mem_wstrb,
  output logic [`XLEN-1:0]     mem_addr,
  output logic [`XLEN-1:0]     mem_wdata,
  input  logic                 mem_ready,
  input  logic                 mem_rvalid,
  input  logic [`XLEN-1:0]     mem_rdata,

  output logic                 resp_err
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    SRC_IRAM = 1'b0,
    SRC_DRAM = 1'b1
  } src_e;

  // Ordering FIFO state
  src_e          fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Round-robin pointer: 1 favours dram
  logic rr_dram_q;
  logic resp_err_q;

  logic gnt_i;
  logic gnt_d;
  logic can_grant;
  logic accept;
  logic push;
  logic pop;
  logic fifo_empty;
  src_e head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count_q == '0);
  // Full blocks grants even when a pop happens this cycle; this keeps the
  // grant path independent of mem_rvalid. Reset also masks every grant.
  assign can_grant  = rst_b && (count_q != CW'(MAX_OUTSTANDING));

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (can_grant) begin
      if (DRAM_PRIORITY != 0) begin
        gnt_d = dram_req;
        gnt_i = iram_req && !dram_req;
      end else begin
        gnt_d = dram_req && (!iram_req || rr_dram_q);
        gnt_i = iram_req && (!dram_req || !rr_dram_q);
      end
    end
  end

  // Forwarding: payload is zero when nothing is granted
  assign mem_req   = gnt_i | gnt_d;
  assign mem_write = (gnt_d & dram_write) | (gnt_i & iram_write);
  assign mem_wstrb = gnt_d ? dram_wstrb : (gnt_i ? iram_wstrb : '0);
  assign mem_addr  = gnt_d ? dram_addr  : (gnt_i ? iram_addr  : '0);
  assign mem_wdata = gnt_d ? dram_wdata : (gnt_i ? iram_wdata : '0);

  assign iram_ready = gnt_i & mem_ready;
  assign dram_ready = gnt_d & mem_ready;

  assign accept = mem_req & mem_ready;
  assign push   = accept & ~mem_write;
  assign pop    = rst_b & mem_rvalid & ~fifo_empty;
  assign head   = fifo_q[rd_ptr_q];

  // Response routing: head of the FIFO names the destination
  assign iram_rvalid = pop & (head == SRC_IRAM);
  assign dram_rvalid = pop & (head == SRC_DRAM);
  assign iram_rdata  = mem_rdata;
  assign dram_rdata  = mem_rdata;

  assign resp_err = resp_err_q;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_dram_q  <= 1'b1;
      resp_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);

      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (accept) rr_dram_q <= ~rr_dram_q;

      if (mem_rvalid && fifo_empty) resp_err_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; entries are only read between the
  // pointers, which are reset, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= gnt_d ? SRC_DRAM : SRC_IRAM;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Two instances share the requester-side
//   stimulus: u_a uses fixed dram priority, u_b uses round-robin. Each has its
//   own downstream ready/response inputs, so one instance can be held idle
//   (ready low, no responses) while the other is exercised.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_b;

  logic               iram_req, iram_write;
  logic [`XLEN/8-1:0] iram_wstrb;
  logic [`XLEN-1:0]   iram_addr, iram_wdata;
  logic               dram_req, dram_write;
  logic [`XLEN/8-1:0] dram_wstrb;
  logic [`XLEN-1:0]   dram_addr, dram_wdata;

  logic               a_mem_ready, a_mem_rvalid;
  logic [`XLEN-1:0]   a_mem_rdata;
  logic               a_iram_ready, a_iram_rvalid, a_dram_ready, a_dram_rvalid;
  logic [`XLEN-1:0]   a_iram_rdata, a_dram_rdata;
  logic               a_mem_req, a_mem_write, a_resp_err;
  logic [`XLEN/8-1:0] a_mem_wstrb;
  logic [`XLEN-1:0]   a_mem_addr, a_mem_wdata;

  logic               b_mem_ready, b_mem_rvalid;
  logic [`XLEN-1:0]   b_mem_rdata;
  logic               b_iram_ready, b_iram_rvalid, b_dram_ready, b_dram_rvalid;
  logic [`XLEN-1:0]   b_iram_rdata, b_dram_rdata;
  logic               b_mem_req, b_mem_write, b_resp_err;
  logic [`XLEN/8-1:0] b_mem_wstrb;
  logic [`XLEN-1:0]   b_mem_addr, b_mem_wdata;

  int errors = 0;
  int checks = 0;
  int n_i    = 0;
  int n_d    = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_OUTSTANDING(2), .DRAM_PRIORITY(1)) u_a (
    .clk(clk), .rst_b(rst_b),
    .iram_req(iram_req), .iram_write(iram_write), .iram_wstrb(iram_wstrb),
    .iram_addr(iram_addr), .iram_wdata(iram_wdata), .iram_ready(a_iram_ready),
    .iram_rvalid(a_iram_rvalid), .iram_rdata(a_iram_rdata),
    .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_ready(a_dram_ready),
    .dram_rvalid(a_dram_rvalid), .dram_rdata(a_dram_rdata),
    .mem_req(a_mem_req), .mem_write(a_mem_write), .mem_wstrb(a_mem_wstrb),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_ready(a_mem_ready),
    .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata), .resp_err(a_resp_err)
  );

  mem_arbiter #(.MAX_OUTSTANDING(2), .DRAM_PRIORITY(0)) u_b (
    .clk(clk), .rst_b(rst_b),
    .iram_req(iram_req), .iram_write(iram_write), .iram_wstrb(iram_wstrb),
    .iram_addr(iram_addr), .iram_wdata(iram_wdata), .iram_ready(b_iram_ready),
    .iram_rvalid(b_iram_rvalid), .iram_rdata(b_iram_rdata),
    .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_ready(b_dram_ready),
    .dram_rvalid(b_dram_rvalid), .dram_rdata(b_dram_rdata),
    .mem_req(b_mem_req), .mem_write(b_mem_write), .mem_wstrb(b_mem_wstrb),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_ready(b_mem_ready),
    .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata), .resp_err(b_resp_err)
  );

  task automatic check(input string tag, input logic [`XLEN-1:0] obs,
                       input logic [`XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_i(input logic req, input logic [`XLEN-1:0] addr);
    iram_req   = req;
    iram_write = 1'b0;
    iram_wstrb = '0;
    iram_addr  = addr;
    iram_wdata = '0;
  endtask

  task automatic drv_d(input logic req, input logic wr,
                       input logic [`XLEN/8-1:0] strb,
                       input logic [`XLEN-1:0] addr,
                       input logic [`XLEN-1:0] wdata);
    dram_req   = req;
    dram_write = wr;
    dram_wstrb = strb;
    dram_addr  = addr;
    dram_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both sides requesting: nothing may be granted
    rst_b = 1'b0;
    drv_i(1'b1, 'h10);
    drv_d(1'b1, 1'b0, '0, 'h20, '0);
    a_mem_ready = 1'b1; a_mem_rvalid = 1'b0; a_mem_rdata = '0;
    b_mem_ready = 1'b1; b_mem_rvalid = 1'b0; b_mem_rdata = '0;
    #2;
    check("rst_mem_req_a", a_mem_req, 0);
    check("rst_dram_ready_a", a_dram_ready, 0);
    check("rst_iram_ready_a", a_iram_ready, 0);
    check("rst_mem_req_b", b_mem_req, 0);
    step();
    step();
    check("rst_resp_err", a_resp_err, 0);
    check("rst_count", u_a.count_q, 0);
    rst_b = 1'b1;
    drv_i(1'b0, '0);
    drv_d(1'b0, 1'b0, '0, '0, '0);
    b_mem_ready = 1'b0;

    // Fixed priority: dram wins every cycle, responses one cycle later
    for (int k = 0; k < 4; k++) begin
      drv_i(1'b1, 'h10);
      drv_d(1'b1, 1'b0, '0, 'h200 + 4 * k, '0);
      a_mem_rvalid = (k > 0);
      a_mem_rdata  = 'hA000 + k - 1;
      #1;
      check("fp_mem_req", a_mem_req, 1);
      check("fp_mem_addr", a_mem_addr, 'h200 + 4 * k);
      check("fp_dram_ready", a_dram_ready, 1);
      check("fp_iram_ready", a_iram_ready, 0);
      if (k > 0) begin
        check("fp_dram_rvalid", a_dram_rvalid, 1);
        check("fp_dram_rdata", a_dram_rdata, 'hA000 + k - 1);
        check("fp_iram_rvalid", a_iram_rvalid, 0);
      end
      step();
    end
    drv_i(1'b0, '0);
    drv_d(1'b0, 1'b0, '0, '0, '0);
    a_mem_rvalid = 1'b1;
    a_mem_rdata  = 'hA003;
    #1;
    check("fp_drain_rvalid", a_dram_rvalid, 1);
    check("fp_drain_rdata", a_dram_rdata, 'hA003);
    check("fp_drain_mem_req", a_mem_req, 0);
    step();
    a_mem_rvalid = 1'b0;

    // Round-robin: dram, iram, dram, iram
    a_mem_ready = 1'b0;
    b_mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      drv_i(1'b1, 'h300 + 4 * k);
      drv_d(1'b1, 1'b0, '0, 'h400 + 4 * k, '0);
      b_mem_rvalid = (k > 0);
      b_mem_rdata  = 'hB000 + k - 1;
      #1;
      check("rr_dram_ready", b_dram_ready, exp_d);
      check("rr_iram_ready", b_iram_ready, !exp_d);
      check("rr_mem_addr", b_mem_addr, exp_d ? 'h400 + 4 * k : 'h300 + 4 * k);
      if (k > 0) begin
        check("rr_dram_rvalid", b_dram_rvalid, !exp_d);
        check("rr_iram_rvalid", b_iram_rvalid, exp_d);
        check("rr_rdata", exp_d ? b_iram_rdata : b_dram_rdata, 'hB000 + k - 1);
      end
      n_d += int'(b_dram_ready);
      n_i += int'(b_iram_ready);
      step();
    end
    check("rr_dram_share", n_d, 2);
    check("rr_iram_share", n_i, 2);
    drv_i(1'b0, '0);
    drv_d(1'b0, 1'b0, '0, '0, '0);
    b_mem_rdata = 'hB003;
    #1;
    check("rr_drain_iram_rvalid", b_iram_rvalid, 1);
    check("rr_drain_dram_rvalid", b_dram_rvalid, 0);
    step();
    b_mem_rvalid = 1'b0;
    b_mem_ready  = 1'b0;

    // FIFO full: two reads held, third request blocked until first pop
    a_mem_ready = 1'b1;
    drv_i(1'b1, 'h40);
    #1;
    check("full_a_iram_ready", a_iram_ready, 1);
    step();
    drv_i(1'b0, '0);
    drv_d(1'b1, 1'b0, '0, 'h80, '0);
    #1;
    check("full_b_dram_ready", a_dram_ready, 1);
    step();
    drv_i(1'b1, 'h44);
    drv_d(1'b0, 1'b0, '0, '0, '0);
    #1;
    check("full_mem_req", a_mem_req, 0);
    check("full_iram_ready", a_iram_ready, 0);
    check("full_mem_addr", a_mem_addr, 0);
    step();
    check("full_hold_mem_req", a_mem_req, 0);
    step();
    a_mem_rvalid = 1'b1;
    a_mem_rdata  = 'h1111;
    #1;
    check("full_pop1_iram_rvalid", a_iram_rvalid, 1);
    check("full_pop1_iram_rdata", a_iram_rdata, 'h1111);
    check("full_pop1_dram_rvalid", a_dram_rvalid, 0);
    check("full_pop1_mem_req", a_mem_req, 0);
    step();
    a_mem_rdata = 'h2222;
    #1;
    check("full_pop2_dram_rvalid", a_dram_rvalid, 1);
    check("full_pop2_dram_rdata", a_dram_rdata, 'h2222);
    check("full_pop2_iram_rvalid", a_iram_rvalid, 0);
    check("full_resume_mem_req", a_mem_req, 1);
    check("full_resume_iram_ready", a_iram_ready, 1);
    step();
    drv_i(1'b0, '0);
    a_mem_rdata = 'h3333;
    #1;
    check("full_pop3_iram_rvalid", a_iram_rvalid, 1);
    check("full_pop3_iram_rdata", a_iram_rdata, 'h3333);
    step();
    a_mem_rvalid = 1'b0;

    // Write forwarded exactly, no FIFO push, only the iram read responds
    drv_i(1'b1, 'h48);
    drv_d(1'b1, 1'b1, 4'b0011, 'h100, 'hDEADBEEF);
    #1;
    check("wr_mem_write", a_mem_write, 1);
    check("wr_mem_wstrb", a_mem_wstrb, 'h3);
    check("wr_mem_addr", a_mem_addr, 'h100);
    check("wr_mem_wdata", a_mem_wdata, 'hDEADBEEF);
    check("wr_dram_ready", a_dram_ready, 1);
    check("wr_iram_ready", a_iram_ready, 0);
    step();
    drv_d(1'b0, 1'b0, '0, '0, '0);
    #1;
    check("wr_rd_mem_write", a_mem_write, 0);
    check("wr_rd_iram_ready", a_iram_ready, 1);
    check("wr_rd_mem_addr", a_mem_addr, 'h48);
    check("wr_no_iram_rvalid", a_iram_rvalid, 0);
    check("wr_no_dram_rvalid", a_dram_rvalid, 0);
    step();
    drv_i(1'b0, '0);
    a_mem_rvalid = 1'b1;
    a_mem_rdata  = 'h5555;
    #1;
    check("wr_resp_iram_rvalid", a_iram_rvalid, 1);
    check("wr_resp_iram_rdata", a_iram_rdata, 'h5555);
    check("wr_resp_dram_rvalid", a_dram_rvalid, 0);
    check("wr_resp_err", a_resp_err, 0);
    step();

    // Stray response with the FIFO empty
    a_mem_rdata = 'h6666;
    #1;
    check("stray_iram_rvalid", a_iram_rvalid, 0);
    check("stray_dram_rvalid", a_dram_rvalid, 0);
    step();
    a_mem_rvalid = 1'b0;
    #1;
    check("stray_resp_err", a_resp_err, 1);
    step();
    check("stray_resp_err_held", a_resp_err, 1);
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    #1;
    check("stray_rst_resp_err", a_resp_err, 0);
    check("stray_rst_count", u_a.count_q, 0);
    step();

    // Reset with two reads outstanding
    drv_i(1'b1, 'h50);
    #1;
    check("mid_iram_ready", a_iram_ready, 1);
    step();
    drv_i(1'b0, '0);
    drv_d(1'b1, 1'b0, '0, 'h90, '0);
    #1;
    check("mid_dram_ready", a_dram_ready, 1);
    step();
    check("mid_count_full", u_a.count_q, 2);
    rst_b = 1'b0;
    #1;
    check("mid_rst_mem_req", a_mem_req, 0);
    check("mid_rst_dram_ready", a_dram_ready, 0);
    step();
    rst_b = 1'b1;
    drv_d(1'b1, 1'b0, '0, 'hA0, '0);
    #1;
    check("mid_post_count", u_a.count_q, 0);
    check("mid_post_dram_ready", a_dram_ready, 1);
    step();
    drv_d(1'b0, 1'b0, '0, '0, '0);
    a_mem_rvalid = 1'b1;
    a_mem_rdata  = 'h7777;
    #1;
    check("mid_new_dram_rvalid", a_dram_rvalid, 1);
    check("mid_new_dram_rdata", a_dram_rdata, 'h7777);
    check("mid_new_iram_rvalid", a_iram_rvalid, 0);
    check("mid_new_resp_err", a_resp_err, 0);
    step();
    a_mem_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
